bcd_adder: RTL and testbench



---
 rtl/bcd_adder.sv | 75 +++++++
 tb/tb_bcd_adder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bcd_adder.sv
// Single-digit BCD adder: in1 + in2 + Cin -> registered tens (MSout) and units (LSout) digits.
// A result is captured only on in_valid; err flags an operand above 9 when CHECK_INPUTS is set.
module bcd_adder #(
  parameter bit CHECK_INPUTS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       Cin,
  output logic [3:0] MSout,
  output logic [3:0] LSout,
  output logic       out_valid,
  output logic       err
);

  // Handshake: in_valid qualifies in1/in2/Cin for one cycle; out_valid pulses exactly one
  // cycle later with that result. There is no ready; a result is produced every valid cycle.

  logic [4:0] sum_w;
  logic [4:0] adj_w;
  logic       illegal_w;

  logic [3:0] ms_d, ms_q;
  logic [3:0] ls_d, ls_q;
  logic       err_d, err_q;
  logic       valid_d, valid_q;

  assign sum_w     = 5'(in1) + 5'(in2) + 5'(Cin);
  assign adj_w     = sum_w - 5'd10;
  assign illegal_w = CHECK_INPUTS && ((in1 > 4'd9) || (in2 > 4'd9));

  always_comb begin
    ms_d    = ms_q;
    ls_d    = ls_q;
    err_d   = err_q;
    valid_d = 1'b0;
    if (in_valid) begin
      valid_d = 1'b1;
      err_d   = illegal_w;
      if (illegal_w) begin
        // Illegal operands yield a clean zero result rather than a meaningless digit.
        ms_d = 4'd0;
        ls_d = 4'd0;
      end else if (sum_w > 5'd9) begin
        ms_d = 4'd1;
        ls_d = adj_w[3:0];
      end else begin
        ms_d = 4'd0;
        ls_d = sum_w[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_q    <= 4'd0;
      ls_q    <= 4'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ms_q    <= ms_d;
      ls_q    <= ls_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign MSout     = ms_q;
  assign LSout     = ls_q;
  assign err       = err_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_bcd_adder.sv
// Bench for bcd_adder: directed steps then random operands, each result checked one cycle
// after its operands against a decimal reference model.
module tb_bcd_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in1;
  logic [3:0] in2;
  logic       Cin;
  logic [3:0] MSout;
  logic [3:0] LSout;
  logic       out_valid;
  logic       err;

  int checks;
  int failures;

  // Reference state: what the outputs must show after the most recent clock edge.
  int exp_ms;
  int exp_ls;
  int exp_err;
  int exp_ov;

  bcd_adder #(.CHECK_INPUTS(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .Cin       (Cin),
    .MSout     (MSout),
    .LSout     (LSout),
    .out_valid (out_valid),
    .err       (err)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".MSout"},     int'(MSout),     exp_ms);
    check({tag, ".LSout"},     int'(LSout),     exp_ls);
    check({tag, ".out_valid"}, int'(out_valid), exp_ov);
    check({tag, ".err"},       int'(err),       exp_err);
  endtask

  task automatic model_reset();
    exp_ms  = 0;
    exp_ls  = 0;
    exp_err = 0;
    exp_ov  = 0;
  endtask

  // Decimal model: plain integer sum split into tens and units.
  task automatic model_step(input int a, input int b, input int c, input int v);
    int s;
    if (v == 0) begin
      exp_ov = 0;
    end else begin
      exp_ov = 1;
      if (a > 9 || b > 9) begin
        exp_err = 1;
        exp_ms  = 0;
        exp_ls  = 0;
      end else begin
        s       = a + b + c;
        exp_err = 0;
        exp_ms  = s / 10;
        exp_ls  = s % 10;
      end
    end
  endtask

  // Driver: present operands at negedge, let one posedge capture, sample 1ns later.
  task automatic drive(input int a, input int b, input int c, input int v, input string tag);
    @(negedge clk);
    in1      = 4'(a);
    in2      = 4'(b);
    Cin      = c[0];
    in_valid = v[0];
    @(posedge clk);
    model_step(a, b, c, v);
    #1;
    check_all(tag);
  endtask

  int s_a[13] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
  int s_b[13] = '{5, 6, 7, 8, 9, 5, 6, 7, 8, 9, 7, 8, 9};

  initial begin
    int ra, rb, rc, rv;
    checks   = 0;
    failures = 0;
    in_valid = 1'b0;
    in1      = 4'd0;
    in2      = 4'd0;
    Cin      = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 5, 0, 1, "nocarry_0_5");
    drive(7, 2, 0, 1, "nocarry_7_2");
    drive(4, 9, 0, 1, "carry_4_9");
    drive(2, 9, 0, 1, "carry_2_9");
    drive(1, 8, 0, 1, "boundary_1_8");
    drive(9, 9, 1, 1, "max_9_9_1");
    drive(9, 0, 1, 1, "ten_9_0_1");
    drive(12, 3, 0, 1, "illegal_12_3");
    drive(5, 5, 1, 0, "hold_after_illegal");
    drive(3, 4, 0, 1, "legal_clears_err");
    drive(3, 15, 1, 1, "illegal_in2");
    drive(6, 6, 1, 1, "clear_13");

    for (int i = 0; i < 13; i++) begin
      drive(s_a[i], s_b[i], 0, 1, $sformatf("stream_%0d", i));
    end

    // Asynchronous reset between edges, checked before any further clock edge.
    drive(8, 7, 1, 1, "pre_async_reset");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(9, 8, 0, 1, "after_reset");

    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      rb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      rc = int'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) == 0) ? 0 : 1;
      drive(ra, rb, rc, rv, $sformatf("rand_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
